xio_aperture_ctrl: RTL

- Parametrised successor to the fixed 8-aperture access logic in the top level.
- Takes per-aperture in-range flags and base addresses, plus bus-monitor strobes.
  - Selects the lowest-index hit.
  - Forms the SDRAM address.
  - Runs a req/ack transaction to the SDRAM controller.
- Drives /MPD, /EXTSEL and the A8 data bus for reads; captures A8 write data.
- Adds an abort/drain path when SDRAM misses the A8 cycle.

---
 rtl/xio_aperture_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/xio_aperture_ctrl.sv
// rtl/xio_aperture_ctrl.sv - A8 aperture decode and SDRAM access sequencer
//
// Picks the lowest-index aperture whose in_range flag is set on an A8
// address strobe, forms sd_addr = base + low A8 offset bits, and runs one
// req/ack transaction against the SDRAM controller. Reads drive the A8
// data bus; writes forward the captured A8 data. A read whose SDRAM data
// arrives too late for its A8 cycle is drained and flagged in late_err.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a8_addr_strobe      pulse: a8_addr / a8_rw valid
//   a8_write_strobe     pulse: a8_data_in valid for a write
//   a8_clk_falling      pulse: end of the current A8 cycle
//   a8_rw, a8_addr      A8 direction (1=read) and address
//   a8_data_in          A8 write data
//   in_range, ap_base   per-aperture hit flags and packed base addresses
//   sd_req/we/addr/wdata  request to the SDRAM controller
//   sd_ack, sd_rvalid, sd_rdata  SDRAM acceptance and read return
//   a8_data_out, a8_data_oe      read data onto the A8 bus
//   a8_mpd_n, a8_extsel_n        active-low Math-Pak disable / external select
//   hit_index           winning aperture of the last accepted strobe
//   late_err            sticky: a read missed its A8 cycle

module xio_aperture_ctrl #(
    parameter int ANUM = 8,
    parameter int AW   = 27,
    parameter int OFFW = 8,
    localparam int IW  = (ANUM > 1) ? $clog2(ANUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a8_addr_strobe,
    input  logic                a8_write_strobe,
    input  logic                a8_clk_falling,
    input  logic                a8_rw,
    input  logic [15:0]         a8_addr,
    input  logic [7:0]          a8_data_in,
    input  logic [ANUM-1:0]     in_range,
    input  logic [ANUM*AW-1:0]  ap_base,
    output logic                sd_req,
    output logic                sd_we,
    output logic [AW-1:0]       sd_addr,
    output logic [7:0]          sd_wdata,
    input  logic                sd_ack,
    input  logic                sd_rvalid,
    input  logic [7:0]          sd_rdata,
    output logic [7:0]          a8_data_out,
    output logic                a8_data_oe,
    output logic                a8_mpd_n,
    output logic                a8_extsel_n,
    output logic [IW-1:0]       hit_index,
    output logic                late_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_DRIVE,
        S_DRAIN_REQ,    // late read, request still waiting for ack
        S_DRAIN,        // late read, waiting to discard the read data
        S_WR_DATA,
        S_WR_REQ
    } state_t;

    state_t state, state_nx;

    logic          hit;
    logic [IW-1:0] win_idx;
    logic [AW-1:0] win_base;
    logic [AW-1:0] new_addr;
    logic          take_addr;
    logic          take_rdata;
    logic          take_wdata;
    logic          set_late;

    // Only the low OFFW address bits feed the datapath.
    logic unused_addr_bits;
    assign unused_addr_bits = ^a8_addr;

    // Lowest set bit wins: scanning downward lets lower indices overwrite.
    always_comb begin
        hit      = 1'b0;
        win_idx  = '0;
        win_base = '0;
        for (int i = ANUM - 1; i >= 0; i--) begin
            if (in_range[i]) begin
                hit      = 1'b1;
                win_idx  = i[IW-1:0];
                win_base = ap_base[i*AW +: AW];
            end
        end
    end

    // Sum is AW bits wide, so it wraps modulo 2^AW.
    assign new_addr = win_base + {{(AW-OFFW){1'b0}}, a8_addr[OFFW-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            hit_index   <= '0;
            sd_addr     <= '0;
            sd_wdata    <= '0;
            a8_data_out <= '0;
            late_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (take_addr) begin
                hit_index <= win_idx;
                sd_addr   <= new_addr;
            end
            if (take_wdata) begin
                sd_wdata <= a8_data_in;
            end
            if (take_rdata) begin
                a8_data_out <= sd_rdata;
            end
            if (set_late) begin
                late_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        sd_req      = 1'b0;
        sd_we       = 1'b0;
        a8_data_oe  = 1'b0;
        a8_mpd_n    = 1'b1;
        a8_extsel_n = 1'b1;
        take_addr   = 1'b0;
        take_rdata  = 1'b0;
        take_wdata  = 1'b0;
        set_late    = 1'b0;
        case (state)
            S_IDLE: begin
                if (a8_addr_strobe && hit) begin
                    take_addr = 1'b1;
                    state_nx  = a8_rw ? S_RD_REQ : S_WR_DATA;
                end
            end
            S_RD_REQ: begin
                sd_req      = 1'b1;
                a8_mpd_n    = 1'b0;
                a8_extsel_n = 1'b0;
                if (a8_clk_falling) begin
                    set_late = 1'b1;
                    if (sd_ack && sd_rvalid) state_nx = S_IDLE;
                    else if (sd_ack)         state_nx = S_DRAIN;
                    else                     state_nx = S_DRAIN_REQ;
                end else if (sd_ack && sd_rvalid) begin
                    take_rdata = 1'b1;
                    state_nx   = S_RD_DRIVE;
                end else if (sd_ack) begin
                    state_nx = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                a8_mpd_n    = 1'b0;
                a8_extsel_n = 1'b0;
                // The A8 cycle ending wins over data arriving in the same cycle.
                if (a8_clk_falling) begin
                    set_late = 1'b1;
                    state_nx = sd_rvalid ? S_IDLE : S_DRAIN;
                end else if (sd_rvalid) begin
                    take_rdata = 1'b1;
                    state_nx   = S_RD_DRIVE;
                end
            end
            S_RD_DRIVE: begin
                a8_data_oe  = 1'b1;
                a8_mpd_n    = 1'b0;
                a8_extsel_n = 1'b0;
                if (a8_clk_falling) state_nx = S_IDLE;
            end
            S_DRAIN_REQ: begin
                sd_req = 1'b1;
                if (sd_ack && sd_rvalid) state_nx = S_IDLE;
                else if (sd_ack)         state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (sd_rvalid) state_nx = S_IDLE;
            end
            S_WR_DATA: begin
                if (a8_write_strobe) begin
                    take_wdata = 1'b1;
                    state_nx   = S_WR_REQ;
                end else if (a8_clk_falling) begin
                    state_nx = S_IDLE;
                end
            end
            S_WR_REQ: begin
                sd_req = 1'b1;
                sd_we  = 1'b1;
                if (sd_ack) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
